// File: rtl/host_bus_arbiter_pkg.sv
// Shared types and default constants for the host bus arbiter.
package host_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_AH,
    ST_GET_AL,
    ST_GET_DATA,
    ST_HALT,
    ST_ACCESS,
    ST_SEND
  } host_bus_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } host_bus_op_t;

  localparam logic [7:0] HB_CMD_WRITE = 8'h57;
  localparam logic [7:0] HB_CMD_READ  = 8'h52;
  localparam logic [7:0] HB_ACK_BYTE  = 8'h06;

endpackage

// File: rtl/host_bus_arbiter_if.sv
// Bus bundle between the arbiter (slave side) and the UART / CPU / memory
// environment (master side).
interface host_bus_arbiter_if;

  // UART receive side
  logic [7:0]  rxdata;
  logic        rxready;
  logic        rxclk;
  // UART transmit side
  logic [7:0]  txdata;
  logic        txready;
  logic        txclk;
  // CPU side
  logic [15:0] cpuAddr;
  logic [7:0]  cpuDataOut;
  logic        cpuRnw;
  logic        cpuReady;
  logic [7:0]  cpuDataIn;
  // Memory decode side
  logic [15:0] memAddr;
  logic [7:0]  memDataWrite;
  logic        memRnw;
  logic [7:0]  memDataRead;
  // Status
  logic        hostActive;

  modport master (
    output rxdata, rxready, txready, cpuAddr, cpuDataOut, cpuRnw, memDataRead,
    input  rxclk, txdata, txclk, cpuReady, cpuDataIn, memAddr, memDataWrite,
           memRnw, hostActive
  );

  modport slave (
    input  rxdata, rxready, txready, cpuAddr, cpuDataOut, cpuRnw, memDataRead,
    output rxclk, txdata, txclk, cpuReady, cpuDataIn, memAddr, memDataWrite,
           memRnw, hostActive
  );

endinterface

// File: rtl/host_bus_arbiter_cmd_parser.sv
// Host command byte parser: collects opcode, address and (for writes) data
// from the UART and hands a complete command to the arbiter core.
module host_cmd_parser
  import host_bus_pkg::*;
#(
  parameter logic [7:0] CMD_WRITE = HB_CMD_WRITE,
  parameter logic [7:0] CMD_READ  = HB_CMD_READ
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [7:0]   rxdata_i,
  input  logic         rxready_i,
  output logic         rxclk_o,
  input  logic         busy_i,
  output logic         cmdValid_o,
  output host_bus_op_t op_o,
  output logic [15:0]  addr_o,
  output logic [7:0]   data_o
);

  host_bus_state_t state_q;
  host_bus_op_t    op_q;
  logic [7:0]      addrh_q;
  logic [7:0]      addrl_q;
  logic [7:0]      data_q;
  logic            rxclk_q;
  logic            accept;

  // rxready stays high until the UART sees the rxclk pulse, so the cycle in
  // which rxclk is high must not accept the same byte a second time.
  assign accept = rxready_i && !rxclk_q && !busy_i;

  // The last byte of a command is forwarded in the cycle it is accepted so
  // the core can enter HALT on the same edge.
  assign cmdValid_o = accept &&
                      (((state_q == ST_GET_AL) && (op_q == OP_READ)) ||
                       (state_q == ST_GET_DATA));
  assign op_o    = op_q;
  assign addr_o  = {addrh_q, (state_q == ST_GET_AL) ? rxdata_i : addrl_q};
  assign data_o  = (state_q == ST_GET_DATA) ? rxdata_i : data_q;
  assign rxclk_o = rxclk_q;

  // Byte-collection FSM with registered rxclk acknowledge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_READ;
      addrh_q <= '0;
      addrl_q <= '0;
      data_q  <= '0;
      rxclk_q <= 1'b0;
    end else begin
      rxclk_q <= accept;
      if (accept) begin
        case (state_q)
          ST_IDLE: begin
            if (rxdata_i == CMD_WRITE) begin
              op_q    <= OP_WRITE;
              state_q <= ST_GET_AH;
            end else if (rxdata_i == CMD_READ) begin
              op_q    <= OP_READ;
              state_q <= ST_GET_AH;
            end
          end
          ST_GET_AH: begin
            addrh_q <= rxdata_i;
            state_q <= ST_GET_AL;
          end
          ST_GET_AL: begin
            addrl_q <= rxdata_i;
            state_q <= (op_q == OP_WRITE) ? ST_GET_DATA : ST_IDLE;
          end
          ST_GET_DATA: begin
            data_q  <= rxdata_i;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/host_bus_arbiter.sv
// Memory-port arbiter between the 8227 CPU and the UART host loader: stalls
// the CPU, performs one host access on the memory port, answers over UART.
module host_bus_arbiter
  import host_bus_pkg::*;
#(
  parameter logic [7:0] CMD_WRITE = HB_CMD_WRITE,
  parameter logic [7:0] CMD_READ  = HB_CMD_READ,
  parameter logic [7:0] ACK_BYTE  = HB_ACK_BYTE
) (
  input  logic               clk,
  input  logic               nrst,
  host_bus_arbiter_if.slave  bus
);

  host_bus_state_t state_q;
  host_bus_op_t    op_q;
  logic [15:0]     addr_q;
  logic [7:0]      wdata_q;
  logic [7:0]      rdata_q;
  logic            cpuReady_q;
  logic            txclk_q;
  logic [7:0]      txdata_q;

  logic            cmd_valid;
  host_bus_op_t    cmd_op;
  logic [15:0]     cmd_addr;
  logic [7:0]      cmd_data;
  logic            busy;

  assign busy = (state_q != ST_IDLE);

  host_cmd_parser #(
    .CMD_WRITE (CMD_WRITE),
    .CMD_READ  (CMD_READ)
  ) u_parser (
    .clk        (clk),
    .nrst       (nrst),
    .rxdata_i   (bus.rxdata),
    .rxready_i  (bus.rxready),
    .rxclk_o    (bus.rxclk),
    .busy_i     (busy),
    .cmdValid_o (cmd_valid),
    .op_o       (cmd_op),
    .addr_o     (cmd_addr),
    .data_o     (cmd_data)
  );

  // Stall / access / respond FSM. txclk is raised on the edge that enters
  // its pulse cycle, so the ACCESS->SEND edge already launches the response
  // when the transmitter is idle; the edge after the pulse releases the CPU.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_READ;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cpuReady_q <= 1'b1;
      txclk_q    <= 1'b0;
      txdata_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q       <= cmd_op;
            addr_q     <= cmd_addr;
            wdata_q    <= cmd_data;
            cpuReady_q <= 1'b0;
            state_q    <= ST_HALT;
          end
        end
        ST_HALT: begin
          if (!cpuReady_q && bus.cpuRnw) state_q <= ST_ACCESS;
        end
        ST_ACCESS: begin
          rdata_q <= bus.memDataRead;
          state_q <= ST_SEND;
          if (bus.txready) begin
            txclk_q  <= 1'b1;
            txdata_q <= (op_q == OP_READ) ? bus.memDataRead : ACK_BYTE;
          end
        end
        ST_SEND: begin
          if (txclk_q) begin
            txclk_q    <= 1'b0;
            cpuReady_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else if (bus.txready) begin
            txclk_q  <= 1'b1;
            txdata_q <= (op_q == OP_READ) ? rdata_q : ACK_BYTE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Memory-port mux: host owns the port only during ACCESS.
  always_comb begin
    bus.memAddr      = bus.cpuAddr;
    bus.memRnw       = bus.cpuRnw;
    bus.memDataWrite = bus.cpuDataOut;
    bus.cpuDataIn    = bus.memDataRead;
    if (state_q == ST_ACCESS) begin
      bus.memAddr      = addr_q;
      bus.memRnw       = (op_q == OP_READ);
      bus.memDataWrite = wdata_q;
      bus.cpuDataIn    = '0;
    end
  end

  assign bus.cpuReady   = cpuReady_q;
  assign bus.txclk      = txclk_q;
  assign bus.txdata     = txdata_q;
  assign bus.hostActive = (state_q != ST_IDLE);

endmodule

// File: tb/tb_host_bus_arbiter.sv
// Directed bench for host_bus_arbiter with UART, CPU and memory models and a
// response-byte scoreboard.
module tb_host_bus_arbiter;
  import host_bus_pkg::*;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  host_bus_arbiter_if bus();

  host_bus_arbiter #(
    .CMD_WRITE (8'h57),
    .CMD_READ  (8'h52),
    .ACK_BYTE  (8'h06)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory model: RAM below 8000 (512-byte mirror), ROM pattern above.
  logic [7:0] ram [0:511];
  int cpu_halt_wr = 0;

  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h5D;
  endfunction

  assign bus.memDataRead = bus.memAddr[15] ? rom_byte(bus.memAddr) : ram[bus.memAddr[8:0]];

  always @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < 512; i++) ram[i] <= 8'h00;
    end else if (!bus.memRnw && !bus.memAddr[15]) begin
      ram[bus.memAddr[8:0]] <= bus.memDataWrite;
      if (bus.hostActive && bus.memAddr == bus.cpuAddr) cpu_halt_wr <= cpu_halt_wr + 1;
    end
  end

  // CPU model: walks through page 01; reads stall on ready, writes do not.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) bus.cpuAddr <= 16'h0100;
    else if (bus.cpuReady || !bus.cpuRnw) bus.cpuAddr <= {8'h01, bus.cpuAddr[7:0] + 8'd1};
  end

  // Monitor: host-owned cycles, ready/active consistency, response scoreboard.
  logic [7:0]  expq[$];
  int          tx_seen = 0;
  int          acc_cnt = 0;
  int          rdy_bad = 0;
  logic [15:0] acc_addr, acc_cpuaddr;
  logic        acc_rnw;
  logic [7:0]  acc_wdata, acc_cpudin;

  always @(negedge clk) begin
    if (nrst) begin
      if (bus.cpuReady !== !bus.hostActive) rdy_bad++;
      if (bus.memAddr !== bus.cpuAddr || bus.memRnw !== bus.cpuRnw) begin
        acc_cnt++;
        acc_addr    = bus.memAddr;
        acc_rnw     = bus.memRnw;
        acc_wdata   = bus.memDataWrite;
        acc_cpudin  = bus.cpuDataIn;
        acc_cpuaddr = bus.cpuAddr;
      end
      if (bus.txclk === 1'b1) begin
        tx_seen++;
        if (expq.size() == 0) chk("tx_queue", 32'(expq.size()), 1);
        else chk("txdata", bus.txdata, expq.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    bus.rxdata  = b;
    bus.rxready = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (bus.rxclk !== 1'b1 && t < 50);
    chk($sformatf("rxclk_%02h", b), bus.rxclk, 1);
    @(posedge clk);
    #1 bus.rxready = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int t;
    t = 0;
    while (tx_seen == n && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("tx_arrived", tx_seen, n + 1);
  endtask

  initial begin
    int a0, n, h0, t;
    nrst           = 1'b0;
    bus.rxdata     = 8'h00;
    bus.rxready    = 1'b0;
    bus.txready    = 1'b1;
    bus.cpuRnw     = 1'b1;
    bus.cpuDataOut = 8'h00;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;

    // Reset state
    @(negedge clk); #1;
    chk("rst_cpuReady",   bus.cpuReady, 1);
    chk("rst_rxclk",      bus.rxclk, 0);
    chk("rst_txclk",      bus.txclk, 0);
    chk("rst_txdata",     bus.txdata, 8'h00);
    chk("rst_hostActive", bus.hostActive, 0);
    chk("rst_mux_addr",   bus.memAddr, bus.cpuAddr);
    chk("rst_mux_din",    bus.cpuDataIn, bus.memDataRead);

    // Host write 57 00 05 A5
    a0 = acc_cnt; n = tx_seen;
    expq.push_back(8'h06);
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h05); send_byte(8'hA5);
    wait_tx(n);
    chk("wr_acc_count", acc_cnt, a0 + 1);
    chk("wr_acc_addr",  acc_addr, 16'h0005);
    chk("wr_acc_rnw",   acc_rnw, 0);
    chk("wr_acc_data",  acc_wdata, 8'hA5);
    chk("wr_acc_cpudin", acc_cpudin, 8'h00);
    chk("wr_ram5",      ram[9'h005], 8'hA5);
    @(negedge clk); #1;
    chk("wr_release",   bus.cpuReady, 1);
    chk("wr_idle",      bus.hostActive, 0);

    // Host read 52 FF 00 from ROM
    a0 = acc_cnt; n = tx_seen;
    expq.push_back(8'hA2);
    send_byte(8'h52); send_byte(8'hFF); send_byte(8'h00);
    wait_tx(n);
    chk("rd_acc_count", acc_cnt, a0 + 1);
    chk("rd_acc_addr",  acc_addr, 16'hFF00);
    chk("rd_acc_rnw",   acc_rnw, 1);
    chk("rd_cpu_held",  bus.cpuAddr, acc_cpuaddr);
    chk("rd_stalled",   bus.cpuReady, 0);
    @(negedge clk); #1;
    chk("rd_release",   bus.cpuReady, 1);

    // HALT entered while the CPU is writing
    a0 = acc_cnt; n = tx_seen; h0 = cpu_halt_wr;
    bus.cpuDataOut = 8'h3C;
    bus.cpuRnw     = 1'b0;
    expq.push_back(8'hCD);
    send_byte(8'h52); send_byte(8'h80); send_byte(8'h10);
    @(negedge clk); @(negedge clk); #1;
    chk("halt_no_access", acc_cnt, a0);
    chk("halt_active",    bus.hostActive, 1);
    chk("halt_stalled",   bus.cpuReady, 0);
    bus.cpuRnw = 1'b1;
    wait_tx(n);
    chk("halt_cpu_wr",    (cpu_halt_wr - h0) >= 2, 1);
    chk("halt_cpu_data",  ram[{1'b1, bus.cpuAddr[7:0] - 8'd1}], 8'h3C);
    chk("halt_acc_addr",  acc_addr, 16'h8010);
    chk("halt_acc_count", acc_cnt, a0 + 1);
    @(negedge clk); #1;

    // Junk byte, then a read of the location written earlier
    a0 = acc_cnt; n = tx_seen;
    send_byte(8'h33);
    repeat (3) @(negedge clk); #1;
    chk("junk_idle",     bus.hostActive, 0);
    chk("junk_noaccess", acc_cnt, a0);
    chk("junk_notx",     tx_seen, n);
    expq.push_back(8'hA5);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h05);
    wait_tx(n);
    chk("junk_rd_addr",  acc_addr, 16'h0005);
    @(negedge clk); #1;

    // Transmitter busy while in SEND
    a0 = acc_cnt; n = tx_seen;
    bus.txready = 1'b0;
    expq.push_back(8'hA3);
    send_byte(8'h52); send_byte(8'hFF); send_byte(8'h01);
    t = 0;
    while (acc_cnt == a0 && t < 50) begin @(negedge clk); #1; t++; end
    chk("busy_access", acc_cnt, a0 + 1);
    repeat (10) @(negedge clk); #1;
    chk("busy_notx",    tx_seen, n);
    chk("busy_stalled", bus.cpuReady, 0);
    chk("busy_active",  bus.hostActive, 1);
    bus.txready = 1'b1;
    wait_tx(n);
    @(negedge clk); #1;
    chk("busy_release", bus.cpuReady, 1);

    // Reset asserted during ACCESS
    n = tx_seen;
    send_byte(8'h52); send_byte(8'hFF); send_byte(8'h02);
    t = 0;
    while (bus.memAddr !== 16'hFF02 && t < 20) begin @(negedge clk); t++; end
    chk("rst_reach_access", bus.memAddr, 16'hFF02);
    #1 nrst = 1'b0;
    #1;
    chk("rst_acc_ready",  bus.cpuReady, 1);
    chk("rst_acc_active", bus.hostActive, 0);
    chk("rst_acc_txclk",  bus.txclk, 0);
    chk("rst_acc_addr",   bus.memAddr, 16'h0100);
    chk("rst_acc_rnw",    bus.memRnw, 1);
    @(posedge clk); @(posedge clk);
    #1 nrst = 1'b1;
    repeat (5) @(negedge clk); #1;
    chk("rst_acc_notx",   tx_seen, n);
    chk("rst_acc_idle",   bus.hostActive, 0);

    chk("queue_drained",  expq.size(), 0);
    chk("ready_vs_active", rdy_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
